// File: rtl/hybrid_bridge_fsm_pkg.sv
// rtl/hybrid_bridge_fsm_pkg.sv - shared state encoding and gate patterns for the bridge controller
package hybrid_bridge_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DT_POS,
    ST_POS,
    ST_DT_NEG,
    ST_NEG,
    ST_FAULT
  } state_t;

  // Bit order Q1..Q4 as [0]..[3]; each pattern keeps one diagonal of the bridge on
  localparam logic [3:0] GATE_OFF = 4'b0000;
  localparam logic [3:0] GATE_POS = 4'b1001;
  localparam logic [3:0] GATE_NEG = 4'b0110;

  function automatic logic [3:0] gate_of(input state_t st);
    case (st)
      ST_POS:  return GATE_POS;
      ST_NEG:  return GATE_NEG;
      default: return GATE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/hybrid_deadtime_timer.sv
// rtl/hybrid_deadtime_timer.sv - dead-time down-counter, done in the last dead-time cycle
module hybrid_deadtime_timer #(
  parameter int DEAD_TIME = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  output logic o_done
);

  localparam logic [7:0] LOAD_VAL = 8'(DEAD_TIME);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done while the count reads 1 so the owner leaves dead time after exactly DEAD_TIME cycles
  assign o_done = (cnt_q == 8'd1);

endmodule

// File: rtl/hybrid_bridge_fsm.sv
// rtl/hybrid_bridge_fsm.sv - full-bridge gate sequencer with dead time, fault latch and half-period measurement
module hybrid_bridge_fsm
  import hybrid_bridge_fsm_pkg::*;
#(
  parameter int DEAD_TIME = 10,
  parameter int PERIOD_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [3:0]          i_signal,
  output logic [3:0]          o_gate,
  output logic                o_sigma,
  output logic                o_fault,
  output logic [PERIOD_W-1:0] o_half_period
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic                tmr_load, tmr_done;
  logic                jump_pos, jump_neg, fault_in, enable_in, in_run;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc, half_q, half_d;
  logic [3:0]          gate_q;
  logic                sigma_q, fault_q;

  assign jump_pos  = i_signal[0];
  assign jump_neg  = i_signal[1];
  assign fault_in  = i_signal[2];
  assign enable_in = i_signal[3];

  hybrid_deadtime_timer #(.DEAD_TIME(DEAD_TIME)) u_dt_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (tmr_load),
    .o_done  (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    if (fault_in) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (!enable_in) state_d = ST_IDLE;
    end else if (!enable_in) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_DT_POS;
        ST_DT_POS: if (tmr_done) state_d = ST_POS;
        ST_POS:    if (jump_neg) state_d = ST_DT_NEG;
        ST_DT_NEG: if (tmr_done) state_d = ST_NEG;
        ST_NEG:    if (jump_pos) state_d = ST_DT_POS;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign tmr_load = ((state_d == ST_DT_POS) && (state_q != ST_DT_POS)) ||
                    ((state_d == ST_DT_NEG) && (state_q != ST_DT_NEG));

  // cnt_q holds conducting cycles minus one, so the exit edge stores the full length
  assign in_run  = (state_q == ST_POS) || (state_q == ST_NEG);
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PERIOD_W'(1);

  always_comb begin
    cnt_d  = '0;
    half_d = half_q;
    if (in_run) begin
      if (state_d == state_q) begin
        cnt_d = cnt_inc;
      end else if ((state_d == ST_DT_POS) || (state_d == ST_DT_NEG)) begin
        half_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      gate_q  <= GATE_OFF;
      sigma_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      gate_q  <= gate_of(state_d);
      sigma_q <= (state_d == ST_POS);
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign o_gate        = gate_q;
  assign o_sigma       = sigma_q;
  assign o_fault       = fault_q;
  assign o_half_period = half_q;

endmodule

// File: doc/hybrid_bridge_fsm.md
HYBRID_BRIDGE_FSM -- requirements
Module: hybrid_bridge_fsm

Interface
REQ-001 SHALL have parameter DEAD_TIME, default 10, meaning all-gates-off cycles inserted before any gate turn-on; legal range 1..255.
REQ-002 SHALL have parameter PERIOD_W, default 16, meaning width of the half-period measurement output.
REQ-003 SHALL have port i_clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_signal  input  4  regularized flags: [0] jump-to-positive, [1] jump-to-negative, [2] fault, [3] enable.
REQ-006 SHALL have port o_gate  output  4  full-bridge gate drives, bit order Q1..Q4 as [0]..[3].
REQ-007 SHALL have port o_sigma  output  1  1 = positive leg conducting, 0 otherwise.
REQ-008 SHALL have port o_fault  output  1  latched fault indicator.
REQ-009 SHALL have port o_half_period  output  PERIOD_W  cycle count of last completed POS or NEG interval.

Function
REQ-010 SHALL implement states IDLE, DT_POS, POS, DT_NEG, NEG, FAULT.
REQ-011 SHALL give fault (i_signal[2]=1) top priority: any state -> FAULT on next edge.
REQ-012 SHALL, from any non-FAULT state with enable=0 and no fault, go to IDLE on next edge.
REQ-013 SHALL, in IDLE with enable=1 and no fault, go to DT_POS, loading the dead-time counter with DEAD_TIME.
REQ-014 SHALL stay in DT_POS/DT_NEG exactly DEAD_TIME cycles, then enter POS/NEG respectively.
REQ-015 SHALL ignore jump flags during DT_POS/DT_NEG; the transition always completes.
REQ-016 SHALL, in POS, go to DT_NEG when i_signal[1]=1; i_signal[0] ignored in POS.
REQ-017 SHALL, in NEG, go to DT_POS when i_signal[0]=1; i_signal[1] ignored in NEG.
REQ-018 SHALL register o_gate from the current state: POS -> 4'b1001, NEG -> 4'b0110, all other states -> 4'b0000.
REQ-019 SHALL never assert Q1 with Q2, or Q3 with Q4, in any cycle; the gate-off to gate-on gap SHALL be >= DEAD_TIME cycles.
REQ-020 SHALL drive o_sigma = 1 only in POS, 0 elsewhere.
REQ-021 SHALL count cycles spent in POS or NEG, saturating at 2^PERIOD_W-1, no wrap.
REQ-022 SHALL load that count into o_half_period on leaving POS/NEG toward DT_*, with o_half_period held otherwise.
REQ-023 SHALL not update o_half_period on exit to IDLE or FAULT.
REQ-024 SHALL set o_fault=1 in FAULT and hold FAULT until fault=0 and enable=0 in the same cycle, then go to IDLE with o_fault cleared.
REQ-025 SHALL treat fault and enable=0 asserted together as fault (REQ-011 precedence).

Reset
REQ-026 SHALL, on i_reset=0, immediately force state IDLE, o_gate=0, o_sigma=0, o_fault=0, o_half_period=0, counters=0.
REQ-027 SHALL leave IDLE no earlier than the first edge after i_reset returns high; a reset mid-POS/NEG SHALL turn gates off asynchronously.

Structure
REQ-028 SHALL place the state encoding and the three gate-pattern constants (OFF, POS, NEG) in the shared hybrid-control package.
REQ-029 SHALL implement the dead-time down-counter as one sub-module, hybrid_deadtime_timer, with load, done and async active-low reset.

Verification
REQ-030 SHALL cover startup: DEAD_TIME=3, reset released, enable=1 -> o_gate 0000 for 3 cycles after the IDLE->DT_POS transition, then 1001, o_sigma=1.
REQ-031 SHALL cover a full cycle: in POS for 40 cycles, pulse [1] -> 3 cycles 0000, then 0110, o_half_period=40; pulse [0] after 25 -> o_half_period=25.
REQ-032 SHALL cover a fault in POS: [2]=1 -> o_gate=0000 and o_fault=1 next edge; enable kept at 1 -> stays FAULT; fault=0 and enable=0 -> IDLE, o_fault=0.
REQ-033 SHALL cover a jump during dead time: [1] pulsed in DT_POS and [0]+[1] both high in POS -> DT_POS completes, then only [1] acts.
REQ-034 SHALL cover saturation with PERIOD_W=4: hold POS for 30 cycles, then jump -> o_half_period=15.
REQ-035 SHALL cover reset mid-NEG: i_reset=0 -> o_gate=0000 without waiting for a clock edge; on release, restart passes through DT_POS.
